// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB branch predictor.
package bp_pkg;

  // 2-bit saturating counter encoding; the MSB is the taken prediction.
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // A freshly allocated branch starts weakly taken.
  localparam logic [1:0] CNT_ALLOC = CNT_WT;

  // Entries are sized for the widest supported PC. Narrower configurations
  // keep the unused upper tag/target bits at zero, so they are constant flops.
  localparam int BP_MAX_ADDR_W = 16;

  typedef struct packed {
    logic                     valid;
    logic [BP_MAX_ADDR_W-1:0] tag;
    logic [1:0]               cnt;
    logic [BP_MAX_ADDR_W-1:0] target;
  } bp_entry_t;

  localparam bp_entry_t BP_ENTRY_RST = '{
    valid:  1'b0,
    tag:    '0,
    cnt:    CNT_WNT,
    target: '0
  };

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup and training signals between fetch/decode and the branch predictor.
interface branch_predictor_if #(
  parameter int ADDR_W = 16
);

  logic [ADDR_W-1:0] PC_curr;
  logic              predict_taken;
  logic              btb_hit;
  logic [ADDR_W-1:0] PC_predict;

  logic              update;
  logic [ADDR_W-1:0] PC_update;
  logic              actual_taken;
  logic [ADDR_W-1:0] actual_target;

  // Pipeline side: drives the lookup PC and the resolved branch outcome.
  modport master (
    output PC_curr, update, PC_update, actual_taken, actual_target,
    input  predict_taken, btb_hit, PC_predict
  );

  // Predictor side.
  modport slave (
    input  PC_curr, update, PC_update, actual_taken, actual_target,
    output predict_taken, btb_hit, PC_predict
  );

endinterface

// File: rtl/CLA_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a
// lookahead carry unit across the groups. Carries are fully expanded so
// no carry signal depends on another bit of the same vector.
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  cg;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    logic c1, c2, c3;

    assign gp[j] = &p[4*j +: 4];
    assign gg[j] = g[4*j+3]
                 | (p[4*j+3] & g[4*j+2])
                 | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                 | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);

    assign c1 = g[4*j] | (p[4*j] & cg[j]);
    assign c2 = g[4*j+1] | (p[4*j+1] & g[4*j])
              | (p[4*j+1] & p[4*j] & cg[j]);
    assign c3 = g[4*j+2] | (p[4*j+2] & g[4*j+1])
              | (p[4*j+2] & p[4*j+1] & g[4*j])
              | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);

    assign sum[4*j +: 4] = p[4*j +: 4] ^ {c3, c2, c1, cg[j]};
  end

  assign cg[0] = cin;
  assign cg[1] = gg[0] | (gp[0] & cin);
  assign cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  assign cout  = cg[4];

endmodule

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating up/down counter.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] cnt_next
);

  // Step toward strong taken on inc, toward strong not-taken otherwise; hold at the ends.
  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup is combinational from PC_curr; training writes at most one entry
// per clock and is seen by lookup from the following cycle (no bypass).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;

  bp_entry_t entry_q [ENTRIES];
  bp_entry_t entry_d [ENTRIES];

  // Lookup path
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  bp_entry_t         lk_entry;
  logic              lk_hit;
  logic              lk_taken;
  logic [ADDR_W-1:0] pc_plus2;

  assign lk_idx   = bp.PC_curr[IDX_W:1];
  assign lk_tag   = bp.PC_curr[ADDR_W-1:IDX_W+1];
  assign lk_entry = entry_q[lk_idx];
  assign lk_hit   = lk_entry.valid & (lk_entry.tag == BP_MAX_ADDR_W'(lk_tag));
  assign lk_taken = lk_hit & lk_entry.cnt[1];

  // Sequential fall-through PC; the adder wraps modulo 2^ADDR_W.
  if (ADDR_W == 16) begin : g_cla
    logic unused_cla_cout;
    CLA_16bit u_pc_inc (
      .a    (bp.PC_curr),
      .b    (16'd2),
      .cin  (1'b0),
      .sum  (pc_plus2),
      .cout (unused_cla_cout)
    );
  end else begin : g_add
    assign pc_plus2 = bp.PC_curr + ADDR_W'(2);
  end

  assign bp.btb_hit       = lk_hit;
  assign bp.predict_taken = lk_taken;
  assign bp.PC_predict    = lk_taken ? lk_entry.target[ADDR_W-1:0] : pc_plus2;

  // Training path
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  bp_entry_t        up_entry;
  logic             up_hit;
  logic [1:0]       up_cnt_next;
  logic             unused_upd_lsb;

  assign up_idx         = bp.PC_update[IDX_W:1];
  assign up_tag         = bp.PC_update[ADDR_W-1:IDX_W+1];
  assign up_entry       = entry_q[up_idx];
  assign up_hit         = up_entry.valid & (up_entry.tag == BP_MAX_ADDR_W'(up_tag));
  assign unused_upd_lsb = bp.PC_update[0];

  sat_counter2 u_cnt (
    .cnt      (up_entry.cnt),
    .inc      (bp.actual_taken),
    .cnt_next (up_cnt_next)
  );

  // Next table state: train a hit, allocate on a taken miss, ignore a not-taken miss.
  always_comb begin
    entry_d = entry_q;
    if (bp.update) begin
      if (up_hit) begin
        entry_d[up_idx].cnt = up_cnt_next;
        if (bp.actual_taken) begin
          entry_d[up_idx].target = BP_MAX_ADDR_W'(bp.actual_target);
        end
      end else if (bp.actual_taken) begin
        entry_d[up_idx] = '{
          valid:  1'b1,
          tag:    BP_MAX_ADDR_W'(up_tag),
          cnt:    CNT_ALLOC,
          target: BP_MAX_ADDR_W'(bp.actual_target)
        };
      end
    end
  end

  // Table storage; reset clears every entry and drops any same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= BP_ENTRY_RST;
      end
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a 16-bit/16-entry instance and a
// 12-bit/4-entry instance sharing clock and reset.
module tb_branch_predictor;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  branch_predictor_if #(.ADDR_W(16)) bif16 ();
  branch_predictor_if #(.ADDR_W(12)) bif12 ();

  branch_predictor #(.ADDR_W(16), .ENTRIES(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bp  (bif16)
  );

  branch_predictor #(.ADDR_W(12), .ENTRIES(4)) dut12 (
    .clk (clk),
    .rst (rst),
    .bp  (bif12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic upd16(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
    bif16.update        = 1'b1;
    bif16.PC_update     = pc;
    bif16.actual_taken  = taken;
    bif16.actual_target = tgt;
    @(posedge clk);
    #1;
    bif16.update = 1'b0;
  endtask

  task automatic upd12(input logic [11:0] pc, input logic taken, input logic [11:0] tgt);
    bif12.update        = 1'b1;
    bif12.PC_update     = pc;
    bif12.actual_taken  = taken;
    bif12.actual_target = tgt;
    @(posedge clk);
    #1;
    bif12.update = 1'b0;
  endtask

  task automatic look16(input logic [15:0] pc, output logic [17:0] obs);
    bif16.PC_curr = pc;
    #1;
    obs = {bif16.btb_hit, bif16.predict_taken, bif16.PC_predict};
  endtask

  task automatic look12(input logic [11:0] pc, output logic [13:0] obs);
    bif12.PC_curr = pc;
    #1;
    obs = {bif12.btb_hit, bif12.predict_taken, bif12.PC_predict};
  endtask

  task automatic test_reset;
    logic [17:0] obs;
    logic [15:0] pc;
    logic [15:0] exp_pc;
    rst = 1'b1;
    bif16.update = 1'b1;
    bif16.PC_update = 16'h0010;
    bif16.actual_taken = 1'b1;
    bif16.actual_target = 16'h0040;
    repeat (2) @(posedge clk);
    #1;
    bif16.update = 1'b0;
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b00, 16'h0012}) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, {2'b00, 16'h0012});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 128; i++) begin
      pc = 16'(i * 2);
      exp_pc = pc + 16'd2;
      look16(pc, obs);
      n_checks++;
      if (obs !== {2'b00, exp_pc}) begin
        n_fail++;
        $display("FAIL reset_sweep pc=%h: got %h expected %h", pc, obs, {2'b00, exp_pc});
      end
    end
    look16(16'hFFFE, obs);
    n_checks++;
    if (obs !== {2'b00, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_wrap: got %h expected %h", obs, {2'b00, 16'h0000});
    end
  endtask

  task automatic test_alloc;
    logic [17:0] obs;
    upd16(16'h0010, 1'b1, 16'h0040);
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b11, 16'h0040}) begin
      n_fail++;
      $display("FAIL alloc_hit: got %h expected %h", obs, {2'b11, 16'h0040});
    end
    upd16(16'h0020, 1'b0, 16'h1234);
    look16(16'h0020, obs);
    n_checks++;
    if (obs !== {2'b00, 16'h0022}) begin
      n_fail++;
      $display("FAIL alloc_nt_miss: got %h expected %h", obs, {2'b00, 16'h0022});
    end
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b11, 16'h0040}) begin
      n_fail++;
      $display("FAIL alloc_kept: got %h expected %h", obs, {2'b11, 16'h0040});
    end
  endtask

  task automatic test_saturation;
    logic [17:0] obs;
    // 10 -> 11 -> 11 -> 11, target replaced by the latest taken target
    repeat (3) upd16(16'h0010, 1'b1, 16'h0050);
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b11, 16'h0050}) begin
      n_fail++;
      $display("FAIL sat_top: got %h expected %h", obs, {2'b11, 16'h0050});
    end
    // 11 -> 10: still taken, so the counter really sat at 11; target untouched
    upd16(16'h0010, 1'b0, 16'h9998);
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b11, 16'h0050}) begin
      n_fail++;
      $display("FAIL sat_strong: got %h expected %h", obs, {2'b11, 16'h0050});
    end
    // 10 -> 01
    upd16(16'h0010, 1'b0, 16'h9998);
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b10, 16'h0012}) begin
      n_fail++;
      $display("FAIL sat_weak_nt: got %h expected %h", obs, {2'b10, 16'h0012});
    end
    // 01 -> 00 and held there
    repeat (5) upd16(16'h0010, 1'b0, 16'h9998);
    upd16(16'h0010, 1'b1, 16'h0060);
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b10, 16'h0012}) begin
      n_fail++;
      $display("FAIL sat_bottom: got %h expected %h", obs, {2'b10, 16'h0012});
    end
    // 01 -> 10 with the new target
    upd16(16'h0010, 1'b1, 16'h0060);
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b11, 16'h0060}) begin
      n_fail++;
      $display("FAIL sat_recover: got %h expected %h", obs, {2'b11, 16'h0060});
    end
  endtask

  task automatic test_alias;
    logic [17:0] obs;
    upd16(16'h0030, 1'b1, 16'h0070);
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b00, 16'h0012}) begin
      n_fail++;
      $display("FAIL alias_evicted: got %h expected %h", obs, {2'b00, 16'h0012});
    end
    look16(16'h0030, obs);
    n_checks++;
    if (obs !== {2'b11, 16'h0070}) begin
      n_fail++;
      $display("FAIL alias_new: got %h expected %h", obs, {2'b11, 16'h0070});
    end
  endtask

  task automatic test_same_cycle;
    logic [17:0] obs;
    @(negedge clk);
    bif16.update        = 1'b1;
    bif16.PC_update     = 16'h0010;
    bif16.actual_taken  = 1'b1;
    bif16.actual_target = 16'h0080;
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b00, 16'h0012}) begin
      n_fail++;
      $display("FAIL hazard_pre: got %h expected %h", obs, {2'b00, 16'h0012});
    end
    @(posedge clk);
    #1;
    bif16.update = 1'b0;
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b11, 16'h0080}) begin
      n_fail++;
      $display("FAIL hazard_post: got %h expected %h", obs, {2'b11, 16'h0080});
    end
  endtask

  task automatic test_reset_priority;
    logic [17:0] obs;
    rst = 1'b1;
    upd16(16'h0010, 1'b1, 16'h0090);
    rst = 1'b0;
    look16(16'h0010, obs);
    n_checks++;
    if (obs !== {2'b00, 16'h0012}) begin
      n_fail++;
      $display("FAIL rst_prio_upd: got %h expected %h", obs, {2'b00, 16'h0012});
    end
    look16(16'h0030, obs);
    n_checks++;
    if (obs !== {2'b00, 16'h0032}) begin
      n_fail++;
      $display("FAIL rst_prio_clear: got %h expected %h", obs, {2'b00, 16'h0032});
    end
  endtask

  task automatic test_small_config;
    logic [13:0] obs;
    look12(12'hFFE, obs);
    n_checks++;
    if (obs !== {2'b00, 12'h000}) begin
      n_fail++;
      $display("FAIL small_wrap: got %h expected %h", obs, {2'b00, 12'h000});
    end
    upd12(12'h010, 1'b1, 12'h040);
    look12(12'h010, obs);
    n_checks++;
    if (obs !== {2'b11, 12'h040}) begin
      n_fail++;
      $display("FAIL small_alloc: got %h expected %h", obs, {2'b11, 12'h040});
    end
    // 0x018 shares index 0 with 0x010 in a 4-entry table
    look12(12'h018, obs);
    n_checks++;
    if (obs !== {2'b00, 12'h01A}) begin
      n_fail++;
      $display("FAIL small_tag_miss: got %h expected %h", obs, {2'b00, 12'h01A});
    end
    upd12(12'h018, 1'b1, 12'h100);
    look12(12'h010, obs);
    n_checks++;
    if (obs !== {2'b00, 12'h012}) begin
      n_fail++;
      $display("FAIL small_evicted: got %h expected %h", obs, {2'b00, 12'h012});
    end
    look12(12'h018, obs);
    n_checks++;
    if (obs !== {2'b11, 12'h100}) begin
      n_fail++;
      $display("FAIL small_alias: got %h expected %h", obs, {2'b11, 12'h100});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bif16.PC_curr = '0;
    bif16.update = 1'b0;
    bif16.PC_update = '0;
    bif16.actual_taken = 1'b0;
    bif16.actual_target = '0;
    bif12.PC_curr = '0;
    bif12.update = 1'b0;
    bif12.PC_update = '0;
    bif12.actual_taken = 1'b0;
    bif12.actual_target = '0;

    test_reset();
    test_alloc();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_reset_priority();
    test_small_config();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
